// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//   WIDTH-bit universal register: parallel load, shift left/right, rotate
//   left/right, clear and invert, with serial in/out taps, true/complement
//   outputs and a saturating shift counter whose done flag marks a full-word
//   serial transfer.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   en        in   synchronous enable (0 = hold everything, mode ignored)
//   mode      in   [2:0] operation select
//   din       in   [WIDTH-1:0] parallel load data
//   sin_lsb   in   serial bit entering bit 0 on shift left
//   sin_msb   in   serial bit entering bit WIDTH-1 on shift right
//   qout      out  [WIDTH-1:0] register contents
//   qbout     out  [WIDTH-1:0] bitwise complement of qout
//   sout_msb  out  qout[WIDTH-1]
//   sout_lsb  out  qout[0]
//   cnt       out  [CNT_W-1:0] shifts/rotates since last load/clear/reset
//   done      out  1 when cnt has saturated at WIDTH
// -----------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] qout,
  output logic [WIDTH-1:0] qbout,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;
  localparam logic [2:0] MODE_INV   = 3'b111;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_q_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;

  // Saturating increment: the counter parks at WIDTH instead of wrapping.
  assign w_cnt_inc = (r_cnt < CNT_MAX) ? (r_cnt + CNT_ONE) : CNT_MAX;

  // Next-state decode for the data register and the shift counter.
  always_comb begin
    w_q_next   = r_q;
    w_cnt_next = r_cnt;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          w_q_next   = r_q;
          w_cnt_next = r_cnt;
        end
        MODE_LOAD: begin
          w_q_next   = din;
          w_cnt_next = CNT_ZERO;
        end
        MODE_SHL: begin
          w_q_next   = {r_q[WIDTH-2:0], sin_lsb};
          w_cnt_next = w_cnt_inc;
        end
        MODE_SHR: begin
          w_q_next   = {sin_msb, r_q[WIDTH-1:1]};
          w_cnt_next = w_cnt_inc;
        end
        MODE_ROTL: begin
          w_q_next   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_cnt_next = w_cnt_inc;
        end
        MODE_ROTR: begin
          w_q_next   = {r_q[0], r_q[WIDTH-1:1]};
          w_cnt_next = w_cnt_inc;
        end
        MODE_CLEAR: begin
          // Clear goes to all-zeros, deliberately not RESET_VAL.
          w_q_next   = {WIDTH{1'b0}};
          w_cnt_next = CNT_ZERO;
        end
        MODE_INV: begin
          w_q_next   = ~r_q;
          w_cnt_next = r_cnt;
        end
        default: begin
          w_q_next   = r_q;
          w_cnt_next = r_cnt;
        end
      endcase
    end else begin
      w_q_next   = r_q;
      w_cnt_next = r_cnt;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q   <= RESET_VAL;
      r_cnt <= CNT_ZERO;
    end else begin
      r_q   <= w_q_next;
      r_cnt <= w_cnt_next;
    end
  end

  // Derived outputs are pure decodes of registers, so they track qout/cnt
  // in the same cycle and cannot glitch from input activity.
  assign qout     = r_q;
  assign qbout    = ~r_q;
  assign sout_msb = r_q[WIDTH-1];
  assign sout_lsb = r_q[0];
  assign cnt      = r_cnt;
  assign done     = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
//   Directed bench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5). Inputs are
//   driven on the falling edge, outputs sampled on the falling edge after the
//   active rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] din;
  logic             sin_lsb;
  logic             sin_msb;
  logic [WIDTH-1:0] qout;
  logic [WIDTH-1:0] qbout;
  logic             sout_msb;
  logic             sout_lsb;
  logic [CNT_W-1:0] cnt;
  logic             done;

  int total = 0;
  int bad   = 0;

  univ_shift_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .din      (din),
    .sin_lsb  (sin_lsb),
    .sin_msb  (sin_msb),
    .qout     (qout),
    .qbout    (qbout),
    .sout_msb (sout_msb),
    .sout_lsb (sout_lsb),
    .cnt      (cnt),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation from a falling edge, then return on the next falling edge.
  task automatic op(input logic e, input logic [2:0] m, input logic [7:0] d,
                    input logic sl, input logic sm);
    en      = e;
    mode    = m;
    din     = d;
    sin_lsb = sl;
    sin_msb = sm;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] bits;

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'b000; din = 8'h00;
    sin_lsb = 1'b0; sin_msb = 1'b0;

    // Reset asserted mid-cycle: outputs must change without a clock edge.
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_qout",  32'(qout),  32'h0000_00A5);
    chk("rst_qbout", 32'(qbout), 32'h0000_005A);
    chk("rst_cnt",   32'(cnt),   32'd0);
    chk("rst_done",  32'(done),  32'd0);
    #9 rst = 1'b1;
    @(negedge clk);
    chk("rst_hold_qout", 32'(qout), 32'h0000_00A5);

    // Load then serial shift-left of 1,0,1,1,0,0,1,0.
    op(1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
    chk("load00_qout", 32'(qout), 32'h0);
    bits = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      op(1'b1, 3'b010, 8'h00, bits[7-i], 1'b0);
      chk("shl_cnt", 32'(cnt), 32'(i + 1));
      if (i == 6) chk("shl_done_early", 32'(done), 32'd0);
    end
    chk("shl_qout", 32'(qout), 32'h0000_00B2);
    chk("shl_done", 32'(done), 32'd1);
    chk("shl_sout_msb", 32'(sout_msb), 32'd1);
    op(1'b1, 3'b010, 8'h00, 1'b0, 1'b0);
    chk("shl9_qout", 32'(qout), 32'h0000_0064);
    chk("shl9_cnt_sat", 32'(cnt), 32'd8);
    chk("shl9_done", 32'(done), 32'd1);

    // Rotate right around a full word.
    op(1'b1, 3'b001, 8'h81, 1'b0, 1'b0);
    chk("load81_cnt", 32'(cnt), 32'd0);
    op(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
    chk("rotr1_qout", 32'(qout), 32'h0000_00C0);
    chk("rotr1_sout_lsb", 32'(sout_lsb), 32'd0);
    chk("rotr1_cnt", 32'(cnt), 32'd1);
    for (int i = 0; i < 7; i++) op(1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
    chk("rotr8_qout", 32'(qout), 32'h0000_0081);
    chk("rotr8_cnt", 32'(cnt), 32'd8);
    chk("rotr8_done", 32'(done), 32'd1);

    // Rotate left once from 8'h81.
    op(1'b1, 3'b001, 8'h81, 1'b0, 1'b0);
    op(1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    chk("rotl_qout", 32'(qout), 32'h0000_0003);
    chk("rotl_cnt", 32'(cnt), 32'd1);

    // Enable gating, invert and hold.
    op(1'b1, 3'b001, 8'h0F, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) op(1'b0, 3'b010, 8'h00, 1'b1, 1'b0);
    chk("en0_qout", 32'(qout), 32'h0000_000F);
    chk("en0_cnt", 32'(cnt), 32'd0);
    op(1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
    chk("inv_qout", 32'(qout), 32'h0000_00F0);
    chk("inv_qbout", 32'(qbout), 32'h0000_000F);
    chk("inv_cnt", 32'(cnt), 32'd0);
    op(1'b1, 3'b000, 8'h55, 1'b1, 1'b1);
    chk("hold_qout", 32'(qout), 32'h0000_00F0);

    // Shift right with sin_msb=1, then clear.
    op(1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) op(1'b1, 3'b011, 8'h00, 1'b0, 1'b1);
    chk("shr_qout", 32'(qout), 32'h0000_00E0);
    chk("shr_sout_msb", 32'(sout_msb), 32'd1);
    chk("shr_cnt", 32'(cnt), 32'd3);
    op(1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    chk("clr_qout", 32'(qout), 32'h0);
    chk("clr_cnt", 32'(cnt), 32'd0);
    chk("clr_done", 32'(done), 32'd0);

    // Reset in the middle of a shift sequence.
    op(1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) op(1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
    chk("mid_qout", 32'(qout), 32'h0000_001F);
    chk("mid_cnt", 32'(cnt), 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("midrst_qout", 32'(qout), 32'h0000_00A5);
    chk("midrst_cnt", 32'(cnt), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("postrst_qout", 32'(qout), 32'h0000_004B);
    chk("postrst_cnt", 32'(cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit register with true and complement outputs.
- Adds parallel load, shift left/right, rotate left/right, synchronous clear, invert, and serial in/out.
- Includes a saturating shift counter with a done flag, so serialiser/deserialiser logic in the lab designs can detect a full word transfer.
- Sits between datapath registers and serial links.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into qout on reset.
- CNT_W, $clog2(WIDTH+1), shift counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  synchronous enable; 0 = hold everything.
- mode  input  3  operation select (see Behaviour).
- din  input  WIDTH  parallel load data.
- sin_lsb  input  1  serial bit entering bit 0 on shift left.
- sin_msb  input  1  serial bit entering bit WIDTH-1 on shift right.
- qout  output  WIDTH  register contents.
- qbout  output  WIDTH  bitwise complement of qout, always ~qout.
- sout_msb  output  1  qout[WIDTH-1] (serial out for shift left).
- sout_lsb  output  1  qout[0] (serial out for shift right).
- cnt  output  CNT_W  shifts/rotates since the last load, clear or reset; saturates at WIDTH.
- done  output  1  1 when cnt == WIDTH.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-operation):
  - qout = RESET_VAL, qbout = ~RESET_VAL, cnt = 0, done = 0.
  - Held while rst=0; normal operation resumes on the first rising clk edge after rst returns to 1.
- All non-reset updates occur on the rising edge of clk, with 1-cycle latency from inputs to qout/cnt.
- en=0: qout and cnt hold; mode is ignored.
- en=1, per mode:
  - 000 hold: qout, cnt unchanged.
  - 001 load: qout <= din; cnt <= 0.
  - 010 shift left: qout <= {qout[WIDTH-2:0], sin_lsb}; cnt increments.
  - 011 shift right: qout <= {sin_msb, qout[WIDTH-1:1]}; cnt increments.
  - 100 rotate left: qout <= {qout[WIDTH-2:0], qout[WIDTH-1]}; cnt increments.
  - 101 rotate right: qout <= {qout[0], qout[WIDTH-1:1]}; cnt increments.
  - 110 clear: qout <= 0 (not RESET_VAL); cnt <= 0.
  - 111 invert: qout <= ~qout; cnt unchanged.
- Counter rules:
  - "Increments" means cnt <= cnt+1 if cnt < WIDTH, else it stays at WIDTH (saturating; no wrap).
  - Shifts and rotates still modify qout when cnt is saturated.
- done is combinational from cnt: registered-equivalent, no extra latency, glitch-free since cnt is a register.
- qbout, sout_msb and sout_lsb are purely combinational from qout: always consistent with qout in the same cycle.
- X or out-of-range inputs are not defined; mode is fully decoded, so no illegal encodings exist.

Test Plan (WIDTH=8, RESET_VAL=8'hA5 unless noted):
- Reset and complement: rst=0 for 10 ns mid-cycle, then release → qout=8'hA5, qbout=8'h5A, cnt=0, done=0 immediately on assertion, without waiting for clk.
- Load then serial shift: load din=8'h00, then 8 cycles shift-left with sin_lsb = 1,0,1,1,0,0,1,0 → qout=8'hB2; cnt increments 1..8; done=1 after the 8th edge; a 9th shift keeps cnt=8 and gives qout=8'h64 with sin_lsb=0.
- Rotate right: load 8'h81, rotate right 1 → qout=8'hC0, sout_lsb=0; rotate right 7 more → qout=8'h81, cnt=8, done=1.
- Enable gating and invert: load 8'h0F, en=0 with mode=010 for 3 cycles → qout stays 8'h0F, cnt=0; en=1 mode=111 → qout=8'hF0, qbout=8'h0F, cnt=0.
- Shift right with sin_msb=1 from 8'h00, 3 cycles → qout=8'hE0, sout_msb=1, cnt=3; then clear → qout=8'h00, cnt=0, done=0.
- Reset mid-sequence: after 5 shifts (cnt=5), assert rst between clock edges → qout=8'hA5 and cnt=0 immediately; the first edge after release with mode=010, sin_lsb=1 → qout=8'h4B, cnt=1.
